// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word-aligned fetches, tracks queue credit and
// in-order responses, skids responses around pops, and drains stale data after a redirect.
// Optional stall counter output enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl #(
    parameter int               XLEN            = 32,
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = 32'h00000000
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enable,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    input  logic            pop,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRvalid,
    input  logic [31:0]     imemRdata,
    output logic            push,
    output logic [29:0]     instrIn,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     stallCycles,
`endif
    output logic            flush
);

    // Skid storage can never exceed the occupancy credit, so sizing it to the larger of
    // DEPTH and MAX_OUTSTANDING keeps it overflow-free even under a long pop burst.
    localparam int SKID_DEPTH = (DEPTH > MAX_OUTSTANDING) ? DEPTH : MAX_OUTSTANDING;
    localparam int SW         = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW         = $clog2(DEPTH + SKID_DEPTH + MAX_OUTSTANDING + 1) + 1;

    localparam logic [CW-1:0]   ZERO_C  = '0;
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [CW-1:0]   TWO_C   = CW'(2);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   MAXO_C  = CW'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [CW-1:0]   occ_r, occ_nxt_s;
    logic [CW-1:0]   out_r, out_nxt_s;
    logic [CW-1:0]   discard_r, discard_nxt_s;
    logic [29:0]     skid_r [SKID_DEPTH];
    logic [CW-1:0]   skid_cnt_r;
    logic            enq_s, deq_s, skid_clr_s;
    logic [SW-1:0]   wr_idx_s;
    logic            resp_s, accept_s, credit_ok_s, req_s, push_s;
    logic [29:0]     instr_s;
    logic [CW-1:0]   resp_cw_s, acc_cw_s;
    logic            unused_rdata_s;

    // Responses with nothing in flight belong to requests abandoned by reset.
    assign resp_s      = imemRvalid && (out_r != ZERO_C);
    assign credit_ok_s = (out_r < MAXO_C) && ((occ_r + out_r + skid_cnt_r) < DEPTH_C);
    assign req_s       = (state_r == ST_RUN) && enable && !redirect && credit_ok_s;
    assign accept_s    = req_s && imemGnt;
    assign resp_cw_s   = {{(CW-1){1'b0}}, resp_s};
    assign acc_cw_s    = {{(CW-1){1'b0}}, accept_s};
    assign wr_idx_s    = deq_s ? SW'(skid_cnt_r - ONE_C) : SW'(skid_cnt_r);

    assign imemReq        = req_s;
    assign imemAddr       = pc_r;
    assign push           = push_s;
    assign instrIn        = instr_s;
    assign flush          = redirect;
    assign unused_rdata_s = ^imemRdata[1:0];

    // Next-state, credit bookkeeping and push selection.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        occ_nxt_s     = occ_r;
        out_nxt_s     = out_r + acc_cw_s - resp_cw_s;
        discard_nxt_s = discard_r;
        push_s        = 1'b0;
        instr_s       = 30'd0;
        enq_s         = 1'b0;
        deq_s         = 1'b0;
        skid_clr_s    = 1'b0;

        if (redirect) begin
            pc_nxt_s   = {redirectPc[XLEN-1:2], 2'b00};
            occ_nxt_s  = ZERO_C;
            skid_clr_s = 1'b1;
        end else if (accept_s) begin
            pc_nxt_s = pc_r + PC_STEP;
        end else begin
            pc_nxt_s = pc_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    discard_nxt_s = out_r - resp_cw_s;
                    state_nxt_s   = (discard_nxt_s != ZERO_C) ? ST_DRAIN : ST_RUN;
                end else begin
                    // Skid entries are older than the current response, so they go first.
                    if (!pop && (skid_cnt_r != ZERO_C)) begin
                        push_s  = 1'b1;
                        instr_s = skid_r[0];
                        deq_s   = 1'b1;
                    end else if (!pop && resp_s) begin
                        push_s  = 1'b1;
                        instr_s = imemRdata[31:2];
                    end else begin
                        push_s  = 1'b0;
                        instr_s = 30'd0;
                    end
                    enq_s = resp_s && (pop || (skid_cnt_r != ZERO_C));

                    if (pop) begin
                        if (occ_r >= TWO_C) begin
                            occ_nxt_s = occ_r - TWO_C;
                        end else if (occ_r == ONE_C) begin
                            occ_nxt_s = ZERO_C;
                        end else begin
                            occ_nxt_s = occ_r;
                        end
                    end else if (push_s) begin
                        occ_nxt_s = occ_r + ONE_C;
                    end else begin
                        occ_nxt_s = occ_r;
                    end
                end
            end
            ST_DRAIN: begin
                discard_nxt_s = discard_r - resp_cw_s;
                state_nxt_s   = (discard_nxt_s == ZERO_C) ? ST_RUN : ST_DRAIN;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state, PC and credit counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            occ_r     <= ZERO_C;
            out_r     <= ZERO_C;
            discard_r <= ZERO_C;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            occ_r     <= occ_nxt_s;
            out_r     <= out_nxt_s;
            discard_r <= discard_nxt_s;
        end
    end

    // Skid FIFO: entry 0 is always the oldest response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            skid_cnt_r <= ZERO_C;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_r[i] <= 30'd0;
            end
        end else if (skid_clr_s) begin
            skid_cnt_r <= ZERO_C;
        end else begin
            if (deq_s) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                    skid_r[i] <= skid_r[i+1];
                end
            end
            if (enq_s) begin
                skid_r[wr_idx_s] <= imemRdata[31:2];
            end
            skid_cnt_r <= skid_cnt_r + {{(CW-1){1'b0}}, enq_s} - {{(CW-1){1'b0}}, deq_s};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where fetch was wanted but credit was exhausted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == ST_RUN) && enable && !redirect && !credit_ok_s &&
                     (stall_cnt_r != 32'hFFFFFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stallCycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, all checked
// against a queue-based reference of the fetch/queue/skid rules.
module tb_fetch_ctrl;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'd0;
    logic        pop = 1'b0;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = 32'd0;
    logic        imemReq, push, flush;
    logic [31:0] imemAddr;
    logic [29:0] instrIn;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    bit          m_started;
    int          m_occ, m_out, m_discard;
    logic [31:0] m_pc;
    logic [31:0] m_stall;
    logic [29:0] m_skid[$];
    logic [31:0] m_addr_q[$];
    // Environment memory and observed request log
    logic [31:0] mem_q[$];
    logic [31:0] issued_q[$];

    fetch_ctrl dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .pop        (pop),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .push       (push),
        .instrIn    (instrIn),
`ifdef FETCH_PERF_CNT_EN
        .stallCycles(stallCycles),
`endif
        .flush      (flush)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0003;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_started = 1'b0;
        m_occ = 0;
        m_out = 0;
        m_discard = 0;
        m_pc = 32'h00000000;
        m_stall = 32'd0;
        m_skid.delete();
        m_addr_q.delete();
        mem_q.delete();
    endtask

    task automatic reset_pulse(input int cycles);
        resetn = 1'b0;
        enable = 1'b0;
        redirect = 1'b0;
        pop = 1'b0;
        imemGnt = 1'b0;
        imemRvalid = 1'b0;
        #1;
        model_clear();
        chk("rst_req", {31'd0, imemReq}, 32'd0);
        chk("rst_push", {31'd0, push}, 32'd0);
        chk("rst_instr", {2'd0, instrIn}, 32'd0);
        chk("rst_addr", imemAddr, 32'h00000000);
        chk("rst_flush", {31'd0, flush}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall", stallCycles, 32'd0);
`endif
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // One clock of stimulus; rv: 0 none, 1 respond if memory has work, 2 stray pulse.
    task automatic step(input logic en, input logic rd, input logic [31:0] rpc,
                        input logic pp, input logic gn, input int rv);
        bit          drain, credit, resp, to_skid, ex_req, ex_push, dut_acc, rv_now;
        logic [29:0] ex_instr;
        logic [31:0] word, dut_addr;
        enable = en;
        redirect = rd;
        redirectPc = rpc;
        pop = pp;
        imemGnt = gn;
        imemRvalid = ((rv == 1) && (mem_q.size() > 0)) || (rv == 2);
        imemRdata = (mem_q.size() > 0) ? memword(mem_q[0]) : $urandom;
        #1;
        drain   = (m_discard > 0);
        credit  = (m_out < MAXO) && ((m_occ + m_out + m_skid.size()) < DEPTH);
        ex_req  = m_started && !drain && en && !rd && credit;
        resp    = imemRvalid && (m_out > 0);
        word    = resp ? memword(m_addr_q[0]) : 32'd0;
        ex_push = 1'b0;
        ex_instr = 30'd0;
        if (m_started && !drain && !rd && !pp) begin
            if (m_skid.size() > 0) begin
                ex_push = 1'b1;
                ex_instr = m_skid[0];
            end else if (resp) begin
                ex_push = 1'b1;
                ex_instr = word[31:2];
            end
        end
        chk("req", {31'd0, imemReq}, {31'd0, ex_req});
        chk("addr", imemAddr, m_pc);
        chk("push", {31'd0, push}, {31'd0, ex_push});
        chk("instr", {2'd0, instrIn}, {2'd0, ex_instr});
        chk("flush", {31'd0, flush}, {31'd0, rd});
`ifdef FETCH_PERF_CNT_EN
        chk("stall", stallCycles, m_stall);
        if (m_started && !drain && en && !rd && !credit && (m_stall != 32'hFFFFFFFF))
            m_stall = m_stall + 32'd1;
`endif
        // Advance reference to the state after the edge.
        to_skid = resp && (pp || (m_skid.size() > 0));
        if (resp) begin
            void'(m_addr_q.pop_front());
            m_out--;
        end
        if (rd) begin
            if (m_started) m_discard = m_out;
            if (!m_started && en) m_started = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
            m_occ = 0;
            m_skid.delete();
        end else if (!m_started) begin
            m_started = en;
        end else if (drain) begin
            if (resp) m_discard--;
        end else begin
            if (!pp && (m_skid.size() > 0)) void'(m_skid.pop_front());
            if (to_skid) m_skid.push_back(word[31:2]);
            if (pp) m_occ = m_occ - ((m_occ >= 2) ? 2 : m_occ);
            else if (ex_push) m_occ++;
        end
        if (ex_req && gn) begin
            m_addr_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
            m_out++;
        end
        dut_acc = (imemReq === 1'b1) && gn;
        dut_addr = imemAddr;
        rv_now = imemRvalid;
        @(posedge clock);
        if (rv_now && (mem_q.size() > 0)) void'(mem_q.pop_front());
        if (dut_acc) begin
            mem_q.push_back(dut_addr);
            issued_q.push_back(dut_addr);
        end
        @(negedge clock);
    endtask

    initial begin
        int n0;
        logic [31:0] a0;
        logic [31:0] s0;
        s0 = 32'd0;
        @(negedge clock);
        reset_pulse(3);

        // Streaming fill with one-cycle latency until the queue is full.
        repeat (8) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1);
        chk("fill_count", issued_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk("fill_addr", issued_q[i], 32'(i * 4));
        chk("full_noreq", {31'd0, imemReq}, 32'd0);

        // One pop frees two slots: two further requests.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1);
        n0 = issued_q.size();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 0);
        chk("pop_refill", issued_q.size() - n0, 32'd2);

        // Response coinciding with pop is deferred one cycle through the skid.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 0);

        // Redirect with two in flight: both stale responses dropped.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 0);
        n0 = issued_q.size();
        step(1'b1, 1'b1, 32'h00001003, 1'b0, 1'b1, 0);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1);
        chk("redirect_addr", issued_q[n0], 32'h00001000);

        // Grant withheld: request and address held.
        a0 = imemAddr;
`ifdef FETCH_PERF_CNT_EN
        s0 = stallCycles;
`endif
        repeat (10) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 0);
            chk("nogrant_req", {31'd0, imemReq}, 32'd1);
            chk("nogrant_addr", imemAddr, a0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("nogrant_stall", stallCycles, s0);
`endif

        // Reset mid-transaction, then stray responses must not push.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 0);
        #2;
        reset_pulse(2);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2);
        chk("stray_push", {31'd0, push}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 600) == 0) begin
                reset_pulse(1);
            end else begin
                step(($urandom % 10) != 0, ($urandom % 24) == 0, $urandom,
                     ($urandom % 3) == 0, ($urandom % 4) != 0,
                     (($urandom % 10) < 7) ? 1 : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
